evt_kernel_load_ctrl: RTL and testbench
=======================================

Name: evt_kernel_load_ctrl

Overview:
Sequencer and port arbiter in front of the event-engine kernel weight memory (4 main 32-bit banks plus 1 packed 4-bit tail bank). On a start command it streams kernel words from a valid/ready config stream into the memory. It first writes the main banks in mode 01, then the tail bank in mode 10. While idle it grants engine read requests and returns a read-valid strobe aligned with memory read data. It also latches the kernel broadcast select for the duration of a job.

Parameters:
CHANNEL_NUMBER, 64, kernel channels held in memory
DATA_WIDTH, 32, config/write data width
ADDR_WIDTH, $clog2(CHANNEL_NUMBER)+2, localparam: memory address width (bank = addr[1:0], row = upper bits)
CNT_WIDTH, $clog2(CHANNEL_NUMBER)+1, localparam: width of channel count

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle job start, sampled only in IDLE
clear_i  in  1  synchronous abort, returns to IDLE
n_ch_i  in  CNT_WIDTH  channels to load, sampled with start_i
cfg_sel_i  in  2  broadcast select, sampled with start_i
in_valid_i  in  1  config word valid
in_data_i  in  DATA_WIDTH  config word
in_ready_o  out  1  config word accepted when valid & ready
wr_en_o  out  1  memory write enable
wr_addr_o  out  ADDR_WIDTH  memory write address
wr_data_o  out  DATA_WIDTH  memory write data
mode_o  out  2  memory mode: 00 idle/read, 01 main banks, 10 tail bank
sel_o  out  2  latched broadcast select to memory
rd_req_i  in  1  engine read request
rd_addr_i  in  ADDR_WIDTH  engine read address
rd_gnt_o  out  1  read granted this cycle
rd_addr_o  out  ADDR_WIDTH  read address to memory
rd_valid_o  out  1  memory read data valid (grant + 1 cycle)
busy_o  out  1  job in progress
done_o  out  1  one-cycle job completion pulse

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE. All outputs 0 except rd_addr_o, which follows rd_addr_i. Counters 0, sel_o=00.
- States: IDLE, MAIN, TAIL, DONE.
- IDLE + start_i:
  - n_eff = min(n_ch_i, CHANNEL_NUMBER); latch n_eff; sel_o <= cfg_sel_i.
  - n_eff=0 -> DONE; otherwise -> MAIN. Beat counter = 0.
- MAIN: in_ready_o=1. Each accepted beat k (0..4*n_eff-1) produces, registered next cycle: wr_en_o=1, wr_addr_o=k, wr_data_o=in_data_i, mode_o=01. Beat k=4*n_eff-1 -> TAIL with counter = 0.
- TAIL: in_ready_o=1. Tail beats = ceil(n_eff/2). Accepted beat j produces, next cycle: wr_en_o=1, wr_addr_o=j, mode_o=10. For odd n_eff, the last word is written in full; its lower 16 bits are don't-care. The last beat -> DONE.
- DONE: done_o=1 for exactly one cycle; the final registered write is also on the port this cycle. Next state IDLE.
- wr_en_o=0 and mode_o=00 in any cycle without a write from the previous cycle.
- Gaps on in_valid_i stall the counters; no write is issued for the idle cycles.
- busy_o=1 in MAIN, TAIL and DONE.
- Reads:
  - rd_gnt_o = rd_req_i & (state==IDLE) & ~start_i & ~wr_en_o. Start has priority over a simultaneous read.
  - rd_addr_o = rd_addr_i (combinational).
  - rd_valid_o = registered rd_gnt_o.
  - Requests outside IDLE are held off; the requester must keep rd_req_i asserted.
- clear_i: next cycle state IDLE, counters 0, wr_en_o=0, mode_o=00, in_ready_o=0, no done_o. A beat accepted in the same cycle is discarded. clear_i outranks start_i. sel_o keeps its value.
- start_i outside IDLE is ignored.
- rst_i has priority over clear_i.

Test Plan:
- Reset: assert rst_i 2 cycles -> all outputs 0, busy_o=0, in_ready_o=0.
- start_i with n_ch_i=2, continuous valid, data = beat index:
  - 8 writes addr 0..7 mode 01, then 1 write addr 0 mode 10 with data 8.
  - done_o pulses in the cycle of the final write.
  - busy_o is high 10 cycles.
- n_ch_i=3, in_valid_i toggling 1/0:
  - 12 main writes then 2 tail writes (addr 0,1), no write in gap cycles.
  - Total job length 28 cycles ±1.
- rd_req_i held during the n_ch_i=1 job -> rd_gnt_o=0 until IDLE; first grant the cycle after done_o; rd_valid_o one cycle later.
- clear_i after 5 main beats -> no further writes, no done_o, busy_o=0 next cycle; a new start then works from addr 0.
- Edge inputs:
  - n_ch_i=0 -> done_o the cycle after start, no writes.
  - n_ch_i=100 (CHANNEL_NUMBER=64) -> 256 main + 32 tail writes.
  - start_i and rd_req_i in the same cycle -> no grant.

Source files
------------

// File: rtl/evt_kernel_load_ctrl.sv
// Kernel weight memory load sequencer: streams main-bank then tail-bank words
// from a config stream, and arbitrates engine reads while idle.
module evt_kernel_load_ctrl #(
    parameter int CHANNEL_NUMBER = 64,
    parameter int DATA_WIDTH     = 32,
    localparam int ADDR_WIDTH    = $clog2(CHANNEL_NUMBER) + 2,
    localparam int CNT_WIDTH     = $clog2(CHANNEL_NUMBER) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [CNT_WIDTH-1:0]  n_ch_i,
    input  logic [1:0]            cfg_sel_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [1:0]            mode_o,
    output logic [1:0]            sel_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_gnt_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAIN = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam int XW = CNT_WIDTH + 2;

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  n_eff;
    logic [CNT_WIDTH-1:0]  n_req;
    logic [ADDR_WIDTH-1:0] beat;
    logic [XW-1:0]         main_last;
    logic [XW-1:0]         tail_last;
    logic                  last_main;
    logic                  last_tail;
    logic                  loading;
    logic                  accept;

    assign n_req = (n_ch_i > CNT_WIDTH'(CHANNEL_NUMBER)) ? CNT_WIDTH'(CHANNEL_NUMBER) : n_ch_i;

    // Only evaluated while loading, so n_eff is nonzero and nothing underflows.
    assign main_last = {n_eff, 2'b00} - XW'(1);
    assign tail_last = ((XW'(n_eff) + XW'(1)) >> 1) - XW'(1);
    assign last_main = (XW'(beat) == main_last);
    assign last_tail = (XW'(beat) == tail_last);

    assign loading    = (state == MAIN) || (state == TAIL);
    assign accept     = in_valid_i & loading;
    assign in_ready_o = loading;
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

    // A start in the same cycle wins over a read request.
    assign rd_gnt_o  = rd_req_i & (state == IDLE) & ~start_i & ~wr_en_o;
    assign rd_addr_o = rd_addr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            n_eff      <= '0;
            beat       <= '0;
            sel_o      <= 2'b00;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            mode_o     <= 2'b00;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_gnt_o;
            wr_en_o    <= 1'b0;
            mode_o     <= 2'b00;
            if (clear_i) begin
                state <= IDLE;
                n_eff <= '0;
                beat  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            n_eff <= n_req;
                            sel_o <= cfg_sel_i;
                            beat  <= '0;
                            state <= (n_req == '0) ? DONE : MAIN;
                        end
                    end
                    MAIN: begin
                        if (accept) begin
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= beat;
                            wr_data_o <= in_data_i;
                            mode_o    <= 2'b01;
                            if (last_main) begin
                                beat  <= '0;
                                state <= TAIL;
                            end else begin
                                beat <= beat + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    TAIL: begin
                        if (accept) begin
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= beat;
                            wr_data_o <= in_data_i;
                            mode_o    <= 2'b10;
                            if (last_tail) begin
                                beat  <= '0;
                                state <= DONE;
                            end else begin
                                beat <= beat + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_evt_kernel_load_ctrl.sv
// Bench for evt_kernel_load_ctrl: queue-based job model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_evt_kernel_load_ctrl;
    localparam int CH = 64;
    localparam int DW = 32;
    localparam int AW = $clog2(CH) + 2;
    localparam int CW = $clog2(CH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, start = 1'b0, clear = 1'b0, in_valid = 1'b0, rd_req = 1'b0;
    logic [CW-1:0] n_ch = '0;
    logic [1:0]    cfg_sel = 2'b00;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          in_ready, wr_en, rd_gnt, rd_valid, busy, done;
    logic [AW-1:0] wr_addr, rd_addr_q;
    logic [DW-1:0] wr_data;
    logic [1:0]    mode, sel;

    evt_kernel_load_ctrl #(.CHANNEL_NUMBER(CH), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .n_ch_i(n_ch),
        .cfg_sel_i(cfg_sel), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .mode_o(mode), .sel_o(sel),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt), .rd_addr_o(rd_addr_q),
        .rd_valid_o(rd_valid), .busy_o(busy), .done_o(done)
    );

    int n_tests = 0, n_fail = 0, cyc = 0, busy_cnt = 0;

    // Model: a job is the ordered list of writes it still owes.
    typedef struct { logic [AW-1:0] addr; logic [1:0] mode; } wexp_t;
    wexp_t wq[$];
    bit model_valid = 0, m_active = 0, m_done = 0;
    logic e_wr_en = 0, e_rd_valid = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [1:0] e_mode = 2'b00, e_sel = 2'b00;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; logic [1:0] mode; logic done; } wlog_t;
    wlog_t wlog[$];
    int done_cyc[$], gnt_cyc[$], rdv_cyc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit exp_ready();
        return m_active && wq.size() != 0;
    endfunction

    function automatic bit exp_gnt();
        return rd_req && !m_active && !start && !e_wr_en;
    endfunction

    task automatic model_edge();
        wexp_t w;
        bit g, acc;
        int n;
        if (rst) begin
            wq.delete();
            model_valid = 1; m_active = 0; m_done = 0;
            e_wr_en = 0; e_rd_valid = 0; e_addr = '0; e_data = '0; e_mode = 2'b00; e_sel = 2'b00;
        end else begin
            g = exp_gnt();
            acc = in_valid && exp_ready();
            e_rd_valid = g;
            e_wr_en = 0;
            e_mode = 2'b00;
            if (clear) begin
                m_active = 0; m_done = 0; wq.delete();
            end else if (m_done) begin
                m_active = 0; m_done = 0;
            end else if (m_active) begin
                if (acc) begin
                    w = wq.pop_front();
                    e_wr_en = 1; e_addr = w.addr; e_data = in_data; e_mode = w.mode;
                    if (wq.size() == 0) m_done = 1;
                end
            end else if (start) begin
                n = (int'(n_ch) > CH) ? CH : int'(n_ch);
                e_sel = cfg_sel;
                for (int k = 0; k < 4 * n; k++) wq.push_back('{addr: AW'(k), mode: 2'b01});
                for (int j = 0; j < (n + 1) / 2; j++) wq.push_back('{addr: AW'(j), mode: 2'b10});
                m_active = 1;
                if (n == 0) m_done = 1;
            end
        end
    endtask

    // One cycle: compare on the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        if (model_valid) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("wr_en", 32'(wr_en), 32'(e_wr_en));
            chk("mode", 32'(mode), 32'(e_mode));
            if (e_wr_en) begin
                chk("wr_addr", 32'(wr_addr), 32'(e_addr));
                chk("wr_data", wr_data, e_data);
            end
            chk("sel", 32'(sel), 32'(e_sel));
            chk("rd_gnt", 32'(rd_gnt), 32'(exp_gnt()));
            chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
            chk("rd_addr", 32'(rd_addr_q), 32'(rd_addr));
        end
        if (wr_en) wlog.push_back('{cyc: cyc, addr: wr_addr, data: wr_data, mode: mode, done: done});
        if (done) done_cyc.push_back(cyc);
        if (rd_gnt) gnt_cyc.push_back(cyc);
        if (rd_valid) rdv_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    // pat: 0 continuous valid, 1 toggling, 2 random; data is the accepted-beat index.
    task automatic run_job(input int n, input int pat, input logic [1:0] s);
        int budget, acc, i;
        bit a;
        start = 1; n_ch = CW'(n); cfg_sel = s; in_valid = 0;
        tick();
        start = 0;
        acc = 0; i = 0; budget = 2000;
        while (m_active && budget > 0) begin
            case (pat)
                0: in_valid = 1;
                1: in_valid = (i % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_data = DW'(acc);
            a = in_valid && exp_ready();
            tick();
            if (a) acc++;
            i++; budget--;
        end
        in_valid = 0;
        if (budget == 0) chk("job_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int wb, db, gb, s, nm, nt;
        // Reset
        rd_addr = AW'(8'h5A);
        tick(); tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_addr", 32'(rd_addr_q), 32'h5A);
        rst = 0;
        tick();

        // n=2, continuous
        wb = wlog.size(); db = done_cyc.size(); busy_cnt = 0;
        run_job(2, 0, 2'b11);
        chk("n2_writes", wlog.size() - wb, 9);
        chk("n2_main7_addr", 32'(wlog[wb+7].addr), 7);
        chk("n2_main7_mode", 32'(wlog[wb+7].mode), 1);
        chk("n2_main7_data", wlog[wb+7].data, 7);
        chk("n2_tail_addr", 32'(wlog[wb+8].addr), 0);
        chk("n2_tail_mode", 32'(wlog[wb+8].mode), 2);
        chk("n2_tail_data", wlog[wb+8].data, 8);
        chk("n2_done_with_last", 32'(wlog[wb+8].done), 1);
        chk("n2_done_count", done_cyc.size() - db, 1);
        chk("n2_busy_cycles", busy_cnt, 10);
        chk("n2_sel", 32'(sel), 3);
        tick();

        // n=3, toggling valid
        wb = wlog.size(); busy_cnt = 0;
        run_job(3, 1, 2'b01);
        chk("n3_writes", wlog.size() - wb, 14);
        chk("n3_tail0_addr", 32'(wlog[wb+12].addr), 0);
        chk("n3_tail0_mode", 32'(wlog[wb+12].mode), 2);
        chk("n3_tail1_addr", 32'(wlog[wb+13].addr), 1);
        chk("n3_tail1_mode", 32'(wlog[wb+13].mode), 2);
        chk("n3_job_len", 32'(busy_cnt >= 27 && busy_cnt <= 29), 1);
        tick();

        // read held during an n=1 job
        rd_req = 1; rd_addr = AW'(8'h21);
        gb = gnt_cyc.size(); db = rdv_cyc.size();
        run_job(1, 0, 2'b10);
        chk("rd_no_gnt_busy", gnt_cyc.size() - gb, 0);
        tick(); tick();
        rd_req = 0;
        chk("rd_first_gnt", gnt_cyc[gb], done_cyc[$] + 1);
        chk("rd_valid_lat", rdv_cyc[db], gnt_cyc[gb] + 1);
        tick();

        // clear after 5 main beats
        wb = wlog.size(); db = done_cyc.size();
        start = 1; n_ch = CW'(4); cfg_sel = 2'b01;
        tick();
        start = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'(i);
            tick();
        end
        clear = 1; in_data = DW'(99);
        tick();
        clear = 0; in_valid = 0;
        chk("clr_busy", 32'(busy), 0);
        chk("clr_in_ready", 32'(in_ready), 0);
        chk("clr_wr_en", 32'(wr_en), 0);
        chk("clr_sel_kept", 32'(sel), 1);
        tick(); tick(); tick();
        chk("clr_writes", wlog.size() - wb, 5);
        chk("clr_no_done", done_cyc.size() - db, 0);
        run_job(1, 0, 2'b00);
        chk("clr_restart_addr", 32'(wlog[wb+5].addr), 0);
        chk("clr_restart_mode", 32'(wlog[wb+5].mode), 1);
        chk("clr_restart_data", wlog[wb+5].data, 0);
        tick();

        // n=0
        wb = wlog.size(); s = cyc;
        run_job(0, 0, 2'b10);
        chk("n0_writes", wlog.size() - wb, 0);
        chk("n0_done_cycle", done_cyc[$], s + 1);
        tick();

        // n=100 clamps to 64
        wb = wlog.size(); nm = 0; nt = 0;
        run_job(100, 2, 2'b01);
        for (int i = wb; i < wlog.size(); i++) begin
            if (wlog[i].mode == 2'b01) nm++;
            if (wlog[i].mode == 2'b10) nt++;
        end
        chk("n100_main", nm, 256);
        chk("n100_tail", nt, 32);
        tick();

        // start and read request together
        rd_req = 1; gb = gnt_cyc.size();
        start = 1; n_ch = CW'(1);
        tick();
        start = 0;
        chk("start_beats_rd", gnt_cyc.size() - gb, 0);
        rd_req = 0; in_valid = 1;
        for (int i = 0; i < 8; i++) tick();
        in_valid = 0;
        tick();

        // randomized traffic, with one reset that coincides with clear
        for (int c = 0; c < 4000; c++) begin
            start    = m_active ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 5) == 0);
            n_ch     = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(60, 127)) : CW'($urandom_range(0, 12));
            cfg_sel  = 2'($urandom_range(0, 3));
            clear    = ($urandom_range(0, 120) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            rd_req   = $urandom_range(0, 1) == 1;
            rd_addr  = AW'($urandom);
            rst      = (c == 2000);
            if (rst) clear = 1;
            tick();
        end
        rst = 0; start = 0; clear = 0; in_valid = 0; rd_req = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
